tank_level_emulator: RTL and testbench
======================================

# tank_level_emulator

Synthesizable tank emulator that produces the 6-bit level-sensor word consumed by the level-indicator top level. Two push buttons (fill, drain) are synchronized and debounced, and a small state machine then raises or lowers a fill count one level per step period. The count is presented as a thermometer code on `Levels`, wired in place of the `Sw` switch bank, so the indicator's red/green alarm and seven-segment count can be exercised on the board without toggling switches.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a raw button must hold a new value before it is accepted (20 ms at 50 MHz); minimum 2.
- `STEP_CYCLES`, default 25_000_000: cycles per level step while filling or draining (0.5 s at 50 MHz); minimum 2.

- `Clk` input 1: system clock; all state changes on the rising edge.
- `Rst_n` input 1: one clock; reset is asynchronous and active-low.
- `FillBtn` input 1: raw fill key, active-low (0 = pressed), asynchronous to `Clk`.
- `DrainBtn` input 1: raw drain key, active-low, asynchronous to `Clk`.
- `Hold` input 1: level-sensitive pause switch; 1 freezes the step timer.
- `Levels` output 6: thermometer level word; `Levels[i]` = 1 when the count is greater than i. `Levels[0]` is the bottom sensor.
- `Filling` output 1: high while in FILL.
- `Draining` output 1: high while in DRAIN.
- `Reject` output 1: one-cycle pulse when a press is refused (fill requested at full, or drain at empty).

## Operation
- **Synchronizer:** each key passes through a 2-flop synchronizer, reset value 1 (released).
- **Debounce:** there is one counter per key.
  - The counter increments while the synchronized value differs from the accepted value.
  - It clears whenever the two are equal.
  - When it reaches `DEBOUNCE_CYCLES-1`, the accepted value updates and the counter clears.
  - A press event is a one-cycle pulse on an accepted 1→0 transition. Release produces no event.
- **Count:** 3-bit register, range 0..6, never leaves that range.
- **FSM states:** IDLE, FILL, DRAIN. Reset state is IDLE.
- **IDLE:**
  - Fill press with count < 6 → FILL.
  - Fill press with count = 6 → stay in IDLE and pulse `Reject`.
  - Drain press with count > 0 → DRAIN.
  - Drain press with count = 0 → stay in IDLE and pulse `Reject`.
- **FILL or DRAIN:** any press of either key → IDLE (manual stop). No `Reject` is generated.
- **Simultaneous presses:** fill and drain presses in the same cycle → IDLE from any state, with no `Reject`.
- **Step timer:**
  - Counts 0..`STEP_CYCLES-1` only in FILL/DRAIN with `Hold`=0.
  - Holds its value while `Hold`=1.
  - Clears on every state entry.
  - At terminal count it wraps to 0 and issues a step.
- **Step in FILL:** count +1. If the new count is 6, next state is IDLE (auto-stop at full).
- **Step in DRAIN:** count −1. If the new count is 0, next state is IDLE (auto-stop at empty).
- **Outputs:** `Levels`, `Filling`, `Draining` and `Reject` are registered, decoded from next-state and next-count, so they change in the same edge as the internal state.
- **Reset values:** `Levels`=6'b000000, `Filling`=0, `Draining`=0, `Reject`=0.
  - All counters, the count and the accepted key values (1) are cleared immediately on `Rst_n` low.
  - Reset mid-fill abandons the step with no partial update.
- Any `Levels` pattern other than a thermometer code is illegal and must never appear.

## Timing
- **Key to event:** a clean press held steady reaches its event 2 (sync) + `DEBOUNCE_CYCLES` cycles after the raw edge.
- **Event to outputs:** state and `Filling`/`Draining`/`Reject` update on the edge that samples the event.
- **First step:** occurs `STEP_CYCLES` cycles after entry to FILL/DRAIN, excluding cycles with `Hold`=1.
- **Later steps:** one every `STEP_CYCLES` cycles thereafter.
- **Update edge:** `Levels` and auto-stop update on the edge at which the timer wraps.
- **Full fill:** a complete fill from 0 to 6 with `Hold`=0 takes 6×`STEP_CYCLES` cycles after FILL entry.
- **Bounce:** glitches shorter than `DEBOUNCE_CYCLES` on a raw key produce no event and leave the accepted value unchanged.
- **Reject:** exactly 1 cycle wide.
- **Reset release:** no event is generated on release of reset, even if a key is held low. The key must first be accepted low, so the event fires after the debounce interval.

## Test plan
Directed cases use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8.
- **Reset:** assert `Rst_n`=0 mid-run → `Levels`=000000, `Filling`=`Draining`=`Reject`=0 with no clock edge. After release, the FSM stays in IDLE until a debounced press.
- **Full fill:** FillBtn low for 10 cycles then released, `Hold`=0. `Filling` rises 6 cycles after the edge. `Levels` steps 000001, 000011, … 111111, one step per 8 cycles. `Filling` falls on the 111111 edge.
- **Refused fill:** fill press at count 6 → one-cycle `Reject`, `Levels` unchanged at 111111. A drain press then steps down to 000000 and auto-stops, with `Draining`=0.
- **Debounce and manual stop:** FillBtn low pulses of 1–3 cycles → no state change. A valid fill press then a drain press during FILL at count 2 → IDLE, `Levels`=000011, no `Reject`.
- **Hold:** in FILL at timer value 5, `Hold`=1 for 20 cycles → `Levels` frozen. After `Hold` drops, the next step occurs exactly 3 cycles later.
- **Simultaneous presses:** both keys pressed in the same cycle in IDLE at count 3 → remains IDLE, no `Reject`, `Levels`=000111.

Source files
------------

// File: rtl/tank_level_emulator.sv
`default_nettype none
// tank_level_emulator: debounced fill/drain keys raise or lower a 0..6 level count shown as a thermometer word.
// Revision 1.0
module tank_level_emulator #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 25_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       FillBtn,
  input  logic       DrainBtn,
  input  logic       Hold,
  output logic [5:0] Levels,
  output logic       Filling,
  output logic       Draining,
  output logic       Reject
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_CYCLES - 1);
  localparam logic [2:0] FULL  = 3'd6;
  localparam logic [2:0] EMPTY = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [1:0] raw_keys;
  logic [1:0] press;   // bit 0 = fill, bit 1 = drain

  assign raw_keys = {DrainBtn, FillBtn};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic            sync1;
    logic            sync2;
    logic            accepted;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        sync1    <= 1'b1;
        sync2    <= 1'b1;
        accepted <= 1'b1;
        db_cnt   <= '0;
      end else begin
        sync1 <= raw_keys[k];
        sync2 <= sync1;
        if (sync2 == accepted) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt   <= '0;
          accepted <= sync2;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // Event fires in the cycle the new low value is accepted, so the FSM reacts on that same edge.
    assign press[k] = (sync2 != accepted) && (db_cnt == DB_LAST) && !sync2;
  end

  state_t          state;
  state_t          state_next;
  logic [2:0]      count;
  logic [2:0]      count_next;
  logic [ST_W-1:0] step_cnt;
  logic            step;
  logic            reject_next;
  logic [5:0]      levels_next;

  assign step = (state != IDLE) && !Hold && (step_cnt == ST_LAST);

  always_comb begin
    state_next  = state;
    count_next  = count;
    reject_next = 1'b0;
    if (press[0] && press[1]) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (press[0]) begin
            if (count != FULL) state_next = FILL;
            else               reject_next = 1'b1;
          end else if (press[1]) begin
            if (count != EMPTY) state_next = DRAIN;
            else                reject_next = 1'b1;
          end
        end
        FILL: begin
          if (press[0] || press[1]) begin
            state_next = IDLE;
          end else if (step && count != FULL) begin
            count_next = count + 3'd1;
            if (count == FULL - 3'd1) state_next = IDLE;
          end
        end
        DRAIN: begin
          if (press[0] || press[1]) begin
            state_next = IDLE;
          end else if (step && count != EMPTY) begin
            count_next = count - 3'd1;
            if (count == EMPTY + 3'd1) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    levels_next = '0;
    for (int i = 0; i < 6; i++) begin
      levels_next[i] = (count_next > 3'(i));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      count <= EMPTY;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Timer restarts on every state change, including auto-stop and manual stop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      step_cnt <= '0;
    end else if (state_next != state) begin
      step_cnt <= '0;
    end else if (state != IDLE && !Hold) begin
      step_cnt <= (step_cnt == ST_LAST) ? '0 : step_cnt + ST_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Levels   <= 6'b000000;
      Filling  <= 1'b0;
      Draining <= 1'b0;
      Reject   <= 1'b0;
    end else begin
      Levels   <= levels_next;
      Filling  <= (state_next == FILL);
      Draining <= (state_next == DRAIN);
      Reject   <= reject_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tank_level_emulator.sv
`default_nettype none
// tb_tank_level_emulator: random and directed key stimulus scored against a behavioural tank model.
`timescale 1ns/1ps
module tb_tank_level_emulator;

  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fill_btn = 1'b1;
  logic       drain_btn = 1'b1;
  logic       hold = 1'b0;
  logic [5:0] levels;
  logic       filling;
  logic       draining;
  logic       reject;

  tank_level_emulator #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES(S)
  ) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .FillBtn(fill_btn),
    .DrainBtn(drain_btn),
    .Hold(hold),
    .Levels(levels),
    .Filling(filling),
    .Draining(draining),
    .Reject(reject)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;
  logic [8:0] exp_q[$];

  // Reference model: raw key history, accepted key values, level count, mode, active-cycle tally.
  logic fh[D+2];
  logic dh[D+2];
  logic acc_f, acc_d;
  int   m_mode;     // 0 idle, 1 filling, 2 draining
  int   m_count;
  int   m_elapsed;

  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) begin
      fh[i] = 1'b1;
      dh[i] = 1'b1;
    end
    acc_f = 1'b1;
    acc_d = 1'b1;
    m_mode = 0;
    m_count = 0;
    m_elapsed = 0;
  endtask

  task automatic model_edge(input logic f, input logic d, input logic h, output logic [8:0] e);
    bit flip_f, flip_d, fp, dp, rej;
    int nmode;
    logic [5:0] lv;
    for (int i = D + 1; i > 0; i--) begin
      fh[i] = fh[i-1];
      dh[i] = dh[i-1];
    end
    fh[0] = f;
    dh[0] = d;
    // A key is accepted once its synchronized view (two edges old) has differed for D edges running.
    flip_f = 1'b1;
    flip_d = 1'b1;
    for (int i = 2; i <= D + 1; i++) begin
      if (fh[i] == acc_f) flip_f = 1'b0;
      if (dh[i] == acc_d) flip_d = 1'b0;
    end
    fp = flip_f && acc_f;
    dp = flip_d && acc_d;
    if (flip_f) acc_f = ~acc_f;
    if (flip_d) acc_d = ~acc_d;

    rej = 1'b0;
    nmode = m_mode;
    if (fp && dp) begin
      nmode = 0;
    end else if (m_mode == 0) begin
      if (fp) begin
        if (m_count < 6) nmode = 1; else rej = 1'b1;
      end else if (dp) begin
        if (m_count > 0) nmode = 2; else rej = 1'b1;
      end
    end else if (fp || dp) begin
      nmode = 0;
    end else if (!h) begin
      m_elapsed++;
      if (m_elapsed % S == 0) begin
        m_count = (m_mode == 1) ? m_count + 1 : m_count - 1;
        if (m_count == 6 || m_count == 0) nmode = 0;
      end
    end
    if (nmode != m_mode) m_elapsed = 0;
    m_mode = nmode;
    lv = 6'((1 << m_count) - 1);
    e = {lv, (m_mode == 1), (m_mode == 2), rej};
  endtask

  // One clock of stimulus; r=0 holds reset for this cycle.
  task automatic cycle(input logic f, input logic d, input logic h, input logic r);
    logic [8:0] e;
    logic [8:0] act;
    @(negedge clk);
    fill_btn = f;
    drain_btn = d;
    hold = h;
    if (!r) begin
      if (rst_n) begin
        rst_n = 1'b0;
        #1;
        act = {levels, filling, draining, reject};
        checks++;
        if (act !== 9'd0) begin
          failures++;
          $display("FAIL async_reset t=%0t got=%b expected=%b", $time, act, 9'd0);
        end
      end
      model_reset();
      exp_q.push_back(9'd0);
    end else begin
      rst_n = 1'b1;
      model_edge(f, d, h, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input logic f, input logic d, input logic h, input int n);
    for (int i = 0; i < n; i++) cycle(f, d, h, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic [8:0] e;
    logic [8:0] a;
    forever begin
      @(posedge clk);
      #3;
      edge_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {levels, filling, draining, reject};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs edge=%0d got levels=%b fill=%b drain=%b rej=%b expected levels=%b fill=%b drain=%b rej=%b",
                   edge_no, a[8:3], a[2], a[1], a[0], e[8:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    int kind, len, gap;
    logic hf;
    model_reset();
    // Reset held with the fill key already down: no event on release, only after debounce.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 10);
    run(1'b1, 1'b1, 1'b0, 60);                  // complete fill to 111111
    run(1'b0, 1'b1, 1'b0, 6);                   // refused fill at full
    run(1'b1, 1'b1, 1'b0, 10);
    run(1'b1, 1'b0, 1'b0, 6);                   // drain to empty
    run(1'b1, 1'b1, 1'b0, 60);
    run(1'b1, 1'b0, 1'b0, 6);                   // refused drain at empty
    run(1'b1, 1'b1, 1'b0, 10);
    for (int w = 1; w <= 3; w++) begin          // bounce shorter than debounce
      run(1'b0, 1'b1, 1'b0, w);
      run(1'b1, 1'b1, 1'b0, 6);
    end
    run(1'b0, 1'b1, 1'b0, 6);                   // fill, then manual stop by drain
    run(1'b1, 1'b1, 1'b0, 14);
    run(1'b1, 1'b0, 1'b0, 6);
    run(1'b1, 1'b1, 1'b0, 10);
    run(1'b0, 1'b1, 1'b0, 6);                   // hold freezes the step timer
    run(1'b1, 1'b1, 1'b0, 5);
    run(1'b1, 1'b1, 1'b1, 20);
    run(1'b1, 1'b1, 1'b0, 12);
    run(1'b0, 1'b0, 1'b0, 6);                   // simultaneous presses
    run(1'b1, 1'b1, 1'b0, 10);
    run(1'b1, 1'b0, 1'b0, 6);                   // drain, then reset mid-run
    run(1'b1, 1'b1, 1'b0, 10);
    do_reset(3);
    run(1'b1, 1'b1, 1'b0, 10);
    run(1'b0, 1'b1, 1'b0, 6);                   // fill three steps, then both keys together
    run(1'b1, 1'b1, 1'b0, 26);
    run(1'b1, 1'b0, 1'b0, 6);
    run(1'b1, 1'b1, 1'b0, 8);
    run(1'b0, 1'b0, 1'b0, 6);
    run(1'b1, 1'b1, 1'b0, 10);

    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 99));
      len  = int'($urandom_range(1, 10));
      gap  = int'($urandom_range(0, 40));
      hf   = ($urandom_range(0, 9) == 0);
      if (kind < 45)      run(1'b0, 1'b1, hf, len);
      else if (kind < 85) run(1'b1, 1'b0, hf, len);
      else if (kind < 95) run(1'b0, 1'b0, hf, len);
      else if (kind < 98) run(1'b1, 1'b1, 1'b1, len);
      else                do_reset(len % 3 + 1);
      run(1'b1, 1'b1, ($urandom_range(0, 7) == 0), gap);
    end
    run(1'b1, 1'b1, 1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
